// File: rtl/prime_pkg.sv
// Shared types and helpers for the prime checker divide/modulo datapath.
// Optional quotient support is selected with DIVMOD_UNIT_QUOTIENT_EN.
package prime_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } divmod_state_e;

  // Widest operand supported by the all-ones helper.
  localparam int unsigned MAX_WIDTH = 64;

  // Width of the iteration index that counts WIDTH-1 down to 0.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // Quotient reported for a divide-by-zero: low 'width' bits set.
  function automatic logic [MAX_WIDTH-1:0] quot_all_ones(input int unsigned width);
    logic [MAX_WIDTH-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/divmod_unit_if.sv
// Request/result handshake bundle for divmod_unit.
// quot_o exists only when DIVMOD_UNIT_QUOTIENT_EN is defined.
interface divmod_unit_if #(
  parameter int WIDTH     = 16,
  parameter int TAG_WIDTH = 4
);
  logic                 valid_i;
  logic                 ready_i;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [TAG_WIDTH-1:0] tag_i;
  logic                 valid_o;
  logic                 ready_o;
  logic [WIDTH-1:0]     rem_o;
`ifdef DIVMOD_UNIT_QUOTIENT_EN
  logic [WIDTH-1:0]     quot_o;
`endif
  logic                 is_zero_o;
  logic                 div_zero_o;
  logic [TAG_WIDTH-1:0] tag_o;

  modport slave (
    input  valid_i, a, b, tag_i, ready_o,
    output ready_i, valid_o, rem_o, is_zero_o, div_zero_o, tag_o
`ifdef DIVMOD_UNIT_QUOTIENT_EN
    , output quot_o
`endif
  );

  modport master (
    output valid_i, a, b, tag_i, ready_o,
    input  ready_i, valid_o, rem_o, is_zero_o, div_zero_o, tag_o
`ifdef DIVMOD_UNIT_QUOTIENT_EN
    , input quot_o
`endif
  );

endinterface

// File: rtl/divmod_step.sv
// One restoring-division step: subtract b<<cnt from rem when it fits.
module divmod_step #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] b,
  input  logic [CNT_W-1:0] cnt,
  output logic [WIDTH-1:0] rem_next,
  output logic             ge
);

  logic [2*WIDTH-2:0] d;
  logic [2*WIDTH-2:0] rem_ext;

  // Shifted divisor compared at full width so high bits are never lost.
  always_comb begin
    d        = {{(WIDTH-1){1'b0}}, b} << cnt;
    rem_ext  = {{(WIDTH-1){1'b0}}, rem};
    ge       = (rem_ext >= d);
    rem_next = ge ? (rem - d[WIDTH-1:0]) : rem;
  end

endmodule

// File: rtl/divmod_unit.sv
// Handshaked serial unsigned divider: remainder, flags, tag, optional quotient.
// Define DIVMOD_UNIT_QUOTIENT_EN to build the quotient register and quot_o.
module divmod_unit
  import prime_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int TAG_WIDTH = 4
) (
  input logic          clk,
  input logic          rst_n,
  divmod_unit_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  divmod_state_e        state_q, state_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 valid_q, valid_d;
  logic                 is_zero_q, is_zero_d;
  logic                 div_zero_q, div_zero_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
`ifdef DIVMOD_UNIT_QUOTIENT_EN
  localparam logic [MAX_WIDTH-1:0] QUOT_ONES = quot_all_ones(WIDTH);
  logic [WIDTH-1:0]     quot_q, quot_d;
`endif

  logic             accept;
  logic             out_hs;
  logic             ge;
  logic [WIDTH-1:0] rem_next;

  divmod_step #(
    .WIDTH (WIDTH),
    .CNT_W (CW)
  ) u_step (
    .rem      (rem_q),
    .b        (b_q),
    .cnt      (cnt_q),
    .rem_next (rem_next),
    .ge       (ge)
  );

  assign bus.ready_i    = (state_q == IDLE) || ((state_q == DONE) && bus.ready_o);
  assign accept         = bus.valid_i && bus.ready_i;
  assign out_hs         = valid_q && bus.ready_o;
  assign bus.valid_o    = valid_q;
  assign bus.rem_o      = rem_q;
  assign bus.is_zero_o  = is_zero_q;
  assign bus.div_zero_o = div_zero_q;
  assign bus.tag_o      = tag_q;
`ifdef DIVMOD_UNIT_QUOTIENT_EN
  assign bus.quot_o     = quot_q;
`endif

  // Next-state: iterate in BUSY, release in DONE, and let a new accept
  // override the release so a result handshake and new request share a cycle.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    is_zero_d  = is_zero_q;
    div_zero_d = div_zero_q;
    tag_d      = tag_q;
`ifdef DIVMOD_UNIT_QUOTIENT_EN
    quot_d     = quot_q;
`endif
    case (state_q)
      BUSY: begin
        if (ge) begin
          rem_d = rem_next;
`ifdef DIVMOD_UNIT_QUOTIENT_EN
          quot_d[cnt_q] = 1'b1;
`endif
        end
        if ((cnt_q == '0) || (rem_next == '0)) begin
          state_d   = DONE;
          valid_d   = 1'b1;
          is_zero_d = (rem_next == '0);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_hs) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: ;
    endcase
    if (accept) begin
      tag_d      = bus.tag_i;
      b_d        = bus.b;
      rem_d      = bus.a;
      cnt_d      = CW'(WIDTH - 1);
      div_zero_d = 1'b0;
      is_zero_d  = 1'b0;
      valid_d    = 1'b0;
      state_d    = BUSY;
`ifdef DIVMOD_UNIT_QUOTIENT_EN
      quot_d     = '0;
`endif
      if (bus.b == '0) begin
        state_d    = DONE;
        valid_d    = 1'b1;
        div_zero_d = 1'b1;
        is_zero_d  = (bus.a == '0);
`ifdef DIVMOD_UNIT_QUOTIENT_EN
        quot_d     = QUOT_ONES[WIDTH-1:0];
`endif
      end
    end
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      is_zero_q  <= 1'b0;
      div_zero_q <= 1'b0;
      tag_q      <= '0;
`ifdef DIVMOD_UNIT_QUOTIENT_EN
      quot_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      is_zero_q  <= is_zero_d;
      div_zero_q <= div_zero_d;
      tag_q      <= tag_d;
`ifdef DIVMOD_UNIT_QUOTIENT_EN
      quot_q     <= quot_d;
`endif
    end
  end

endmodule

// File: tb/tb_divmod_unit.sv
// Self-checking bench for divmod_unit (WIDTH=16, TAG_WIDTH=4).
// Quotient checks are active when DIVMOD_UNIT_QUOTIENT_EN is defined.
module tb_divmod_unit;

  logic clk;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  tag;
    logic [15:0] rem;
    logic [15:0] quot;
    logic        is_zero;
    logic        div_zero;
    int          lat;
  } vec_t;

  typedef struct {
    logic [15:0] rem;
    logic [15:0] quot;
    logic        is_zero;
    logic        div_zero;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[12];

  divmod_unit_if #(.WIDTH(16), .TAG_WIDTH(4)) bus ();

  divmod_unit #(.WIDTH(16), .TAG_WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag,
                              input logic [15:0] rem, input logic [15:0] quot,
                              input logic iz, input logic dz, input int lat);
    vec_t v;
    v.a = a; v.b = b; v.tag = tag; v.rem = rem; v.quot = quot;
    v.is_zero = iz; v.div_zero = dz; v.lat = lat;
    return v;
  endfunction

  // Result monitor: pop and compare on every output handshake.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst_n && bus.valid_o && bus.ready_o) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got rem=%0d tag=%0d with nothing expected", bus.rem_o, bus.tag_o);
      end else begin
        e = sb.pop_front();
        chk("rem_o", bus.rem_o, e.rem);
        chk("is_zero_o", bus.is_zero_o, e.is_zero);
        chk("div_zero_o", bus.div_zero_o, e.div_zero);
        chk("tag_o", bus.tag_o, e.tag);
`ifdef DIVMOD_UNIT_QUOTIENT_EN
        chk("quot_o", bus.quot_o, e.quot);
`endif
      end
    end
  end

  task automatic push_exp(input logic [15:0] rem, input logic [15:0] quot,
                          input logic iz, input logic dz, input logic [3:0] tag);
    exp_t e;
    e.rem = rem; e.quot = quot; e.is_zero = iz; e.div_zero = dz; e.tag = tag;
    sb.push_back(e);
  endtask

  // Drive one request at a negedge; returns #1 after the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag,
                      input logic [15:0] rem, input logic [15:0] quot, input logic iz, input logic dz);
    @(negedge clk);
    bus.a = a;
    bus.b = b;
    bus.tag_i = tag;
    bus.valid_i = 1'b1;
    push_exp(rem, quot, iz, dz, tag);
    #1;
    chk("ready_i_at_accept", bus.ready_i, 1'b1);
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
  endtask

  // Counts edges after the accept edge until valid_o is seen; bounded.
  task automatic wait_valid(input int exp_lat, input string name);
    int n;
    bit seen;
    seen = 1'b0;
    for (n = 0; n <= 40; n++) begin
      if (bus.valid_o) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: valid_o never rose, required within 40 edges", name);
    end else if (exp_lat >= 0) begin
      chk(name, n, exp_lat);
    end
  endtask

  task automatic drain();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int unsigned ra, rb;
    // Cases: {a, b, tag, rem, quot, is_zero, div_zero, latency}
    tbl[0]  = mk(16'd100,   16'd7,     4'd3,  16'd2,     16'd14,    1'b0, 1'b0, 16);
    tbl[1]  = mk(16'd96,    16'd8,     4'd4,  16'd0,     16'd12,    1'b1, 1'b0, 14);
    tbl[2]  = mk(16'd0,     16'd5,     4'd1,  16'd0,     16'd0,     1'b1, 1'b0, 1);
    tbl[3]  = mk(16'd37,    16'd0,     4'd9,  16'd37,    16'hFFFF,  1'b0, 1'b1, 0);
    tbl[4]  = mk(16'd65535, 16'd1,     4'd2,  16'd0,     16'd65535, 1'b1, 1'b0, 16);
    tbl[5]  = mk(16'd1000,  16'd10,    4'd7,  16'd0,     16'd100,   1'b1, 1'b0, 14);
    tbl[6]  = mk(16'd12345, 16'd123,   4'd8,  16'd45,    16'd100,   1'b0, 1'b0, 16);
    tbl[7]  = mk(16'd65535, 16'd65535, 4'd10, 16'd0,     16'd1,     1'b1, 1'b0, 16);
    tbl[8]  = mk(16'd5,     16'd9,     4'd11, 16'd5,     16'd0,     1'b0, 1'b0, 16);
    tbl[9]  = mk(16'd0,     16'd0,     4'd12, 16'd0,     16'hFFFF,  1'b1, 1'b1, 0);
    tbl[10] = mk(16'd35,    16'd5,     4'd13, 16'd0,     16'd7,     1'b1, 1'b0, 16);
    tbl[11] = mk(16'd65535, 16'd2,     4'd15, 16'd1,     16'd32767, 1'b0, 1'b0, 16);

    rst_n = 1'b0;
    bus.valid_i = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.tag_i = '0;
    bus.ready_o = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_o", bus.valid_o, 1'b0);
    chk("rst_ready_i", bus.ready_i, 1'b1);
    chk("rst_rem_o", bus.rem_o, 16'd0);
    chk("rst_is_zero_o", bus.is_zero_o, 1'b0);
    chk("rst_div_zero_o", bus.div_zero_o, 1'b0);
    chk("rst_tag_o", bus.tag_o, 4'd0);
`ifdef DIVMOD_UNIT_QUOTIENT_EN
    chk("rst_quot_o", bus.quot_o, 16'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors, ready_o held high.
    for (int i = 0; i < 12; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].tag, tbl[i].rem, tbl[i].quot, tbl[i].is_zero, tbl[i].div_zero);
      wait_valid(tbl[i].lat, "latency");
    end
    drain();

    // Random operands against the language's own / and % operators.
    for (int i = 0; i < 8; i++) begin
      ra = $urandom_range(0, 65535);
      rb = (i < 4) ? $urandom_range(1, 40) : $urandom_range(1, 65535);
      send(16'(ra), 16'(rb), 4'(i), 16'(ra % rb), 16'(ra / rb), (ra % rb) == 0, 1'b0);
      wait_valid(-1, "latency_rand");
    end
    drain();

    // Backpressure: result must hold while ready_o is low.
    @(negedge clk);
    bus.ready_o = 1'b0;
    send(16'd200, 16'd7, 4'd5, 16'd4, 16'd28, 1'b0, 1'b0);
    wait_valid(16, "latency_bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("bp_valid_o", bus.valid_o, 1'b1);
      chk("bp_rem_o", bus.rem_o, 16'd4);
      chk("bp_tag_o", bus.tag_o, 4'd5);
      chk("bp_ready_i", bus.ready_i, 1'b0);
`ifdef DIVMOD_UNIT_QUOTIENT_EN
      chk("bp_quot_o", bus.quot_o, 16'd28);
`endif
    end

    // Release together with a new request: both handshakes in one cycle.
    @(negedge clk);
    bus.ready_o = 1'b1;
    bus.a = 16'd35;
    bus.b = 16'd5;
    bus.tag_i = 4'd6;
    bus.valid_i = 1'b1;
    push_exp(16'd0, 16'd7, 1'b1, 1'b0, 4'd6);
    #1;
    chk("b2b_ready_i", bus.ready_i, 1'b1);
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    chk("b2b_valid_o_dropped", bus.valid_o, 1'b0);
    chk("b2b_ready_i_busy", bus.ready_i, 1'b0);
    wait_valid(16, "latency_b2b");
    drain();

    // Reset during BUSY discards the in-flight request.
    send(16'd65535, 16'd3, 4'd2, 16'd0, 16'd21845, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    chk("midbusy_valid_o", bus.valid_o, 1'b0);
    chk("midbusy_ready_i", bus.ready_i, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    chk("midrst_valid_o", bus.valid_o, 1'b0);
    chk("midrst_ready_i", bus.ready_i, 1'b1);
    chk("midrst_rem_o", bus.rem_o, 16'd0);
    chk("midrst_tag_o", bus.tag_o, 4'd0);
    chk("midrst_is_zero_o", bus.is_zero_o, 1'b0);
    chk("midrst_div_zero_o", bus.div_zero_o, 1'b0);
`ifdef DIVMOD_UNIT_QUOTIENT_EN
    chk("midrst_quot_o", bus.quot_o, 16'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    send(16'd10, 16'd3, 4'd1, 16'd1, 16'd3, 1'b0, 1'b0);
    wait_valid(16, "latency_post_rst");
    drain();

    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/divmod_unit.md
# divmod_unit

Parametrised, handshaked serial divider producing remainder, optional quotient, a remainder-is-zero flag, and a divide-by-zero flag for unsigned WIDTH-bit operands. It succeeds the single-flag modulo checker in the prime checker datapath. Results are registered and held until consumed, and an opaque tag travels with each request. New acceptance is allowed in the same cycle as the output handshake, so the trial-division sequencer can issue back-to-back.

## Interface
- WIDTH, 16: operand width in bits, ≥2.
- TAG_WIDTH, 4: request tag width in bits, ≥1.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- valid_i  input  1  request valid.
- ready_i  output  1  request ready.
- a  input  WIDTH  dividend, unsigned.
- b  input  WIDTH  divisor, unsigned.
- tag_i  input  TAG_WIDTH  request tag, captured on accept.
- valid_o  output  1  result valid.
- ready_o  input  1  result ready.
- rem_o  output  WIDTH  remainder, a mod b.
- quot_o  output  WIDTH  quotient, a / b; present only with DIVMOD_UNIT_QUOTIENT_EN.
- is_zero_o  output  1  remainder == 0.
- div_zero_o  output  1  b was 0.
- tag_o  output  TAG_WIDTH  tag of the current result.

## Operation
- States: IDLE, BUSY, DONE. Reset places the block in IDLE.
- Reset values: valid_o=0, ready_i=1, rem_o=0, quot_o=0, is_zero_o=0, div_zero_o=0, tag_o=0.
- Accept occurs when valid_i && ready_i. It captures a, b, and tag_i and clears div_zero. The iteration index cnt is loaded with WIDTH-1.
- Accept with b==0: go directly to DONE with rem=a, quot=all-ones, div_zero=1, and is_zero = (a==0).
- Accept with b≠0: go to BUSY with rem=a and quot=0.
- Each BUSY cycle performs one restoring step at index cnt:
  - d = b<<cnt, computed 2*WIDTH-1 bits wide.
  - ge = (zero-extended rem ≥ d).
  - If ge: rem -= d[WIDTH-1:0], and quot[cnt] = ge.
  - Otherwise rem and quot hold.
- BUSY exit: go to DONE at the edge where cnt==0 or the next rem==0. On early exit, the remaining quotient bits stay 0, which is correct.
- Otherwise in BUSY, cnt decrements.
- DONE: valid_o=1. All outputs are held stable until valid_o && ready_o.
- ready_i is 1 in IDLE, 0 in BUSY, and equal to ready_o in DONE.
- Output handshake in DONE:
  - With no simultaneous accept: return to IDLE.
  - With a simultaneous accept: load the new request (BUSY, or DONE if b==0). The old result is consumed in that same cycle.
- Inputs are ignored outside an accept cycle.

## Timing
- Let accept be edge E0, and let k be the iteration count, 1..WIDTH.
- valid_o rises after edge Ek.
- b==0: valid_o rises after edge E0, giving one-cycle latency.
- a==0 or an exact early divide terminates early. Example: a=0 gives k=1.
- Worst-case latency is WIDTH cycles from accept to valid_o.
- Throughput is one result per k+1 cycles with ready_o held high. The back-to-back accept removes the IDLE bubble.
- Reset mid-BUSY or mid-DONE: at the next edge the block returns to reset values. The in-flight result is discarded, with no valid_o pulse.

## Configuration
- DIVMOD_UNIT_QUOTIENT_EN defined: the quot register and the quot_o port exist, with behaviour as above.
- DIVMOD_UNIT_QUOTIENT_EN undefined:
  - quot_o port and quotient register are removed.
  - Remainder, flags, tag, timing, and early exit are unchanged.
  - The prime checker builds without this macro.

## Structure
- Package prime_pkg holds:
  - the divmod_state_e typedef (IDLE, BUSY, DONE);
  - the localparam function for the counter width, $clog2(WIDTH);
  - the all-ones quotient constant helper.
- One sub-module: divmod_step, a purely combinational block.
  - Inputs: rem, b, cnt.
  - Outputs: rem_next, ge.
- divmod_step is instantiated once inside divmod_unit.

## Test plan
- WIDTH=16, a=100, b=7, tag=3:
  - Result: rem_o=2, quot_o=14, is_zero_o=0, div_zero_o=0, tag_o=3.
  - valid_o after exactly 16 edges.
- a=96, b=8: rem_o=0, quot_o=12, is_zero_o=1, and early exit occurs before 16 cycles.
- a=0, b=5: valid_o after 1 edge, with rem_o=0 and is_zero_o=1.
- a=37, b=0, tag=9:
  - Result: div_zero_o=1, rem_o=37, quot_o=16'hFFFF, tag_o=9.
  - valid_o in the cycle after accept.
- Backpressure and back-to-back:
  - Hold ready_o=0 for 5 cycles in DONE; outputs must be stable.
  - Then raise ready_o with valid_i=1 (a=35, b=5). The new request is accepted in the same cycle, and the next result is rem=0, quot=7.
- Assert rst_n=0 mid-BUSY (cycle 6 of a=65535, b=3):
  - Next cycle: IDLE, valid_o=0, ready_i=1, all outputs 0.
  - A subsequent a=10, b=3 gives rem_o=1.
